// File: rtl/barrel_pkg.sv
// Shared types and constants for the 16-bit barrel rotator datapath.
package barrel_pkg;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned SHAMT_W = 4;

    typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/rot_stage.sv
// One barrel-rotator stage: rotates left by a fixed AMT when enabled, else passes through.
module rot_stage
    import barrel_pkg::*;
#(
    parameter int unsigned AMT = 1
) (
    input  word_t in,
    input  logic  en,
    output word_t out
);
    word_t w_rot;

    always_comb begin
        w_rot = {in[WIDTH-1-AMT:0], in[WIDTH-1:WIDTH-AMT]};
        out   = en ? w_rot : in;
    end
endmodule

// File: rtl/top.sv
// 16-bit left barrel rotator: four cascaded rotate stages feeding one output register.
module top #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    output logic [WIDTH-1:0] S
);
    import barrel_pkg::*;

    logic [SHAMT_W-1:0] w_n;
    word_t              w_st0;
    word_t              w_st1;
    word_t              w_st2;
    word_t              w_st3;
    logic [WIDTH-1:0]   r_s;

    assign w_n = {s3, s2, s1, s0};

    rot_stage #(.AMT(1)) u_stage0 (.in(A),     .en(w_n[0]), .out(w_st0));
    rot_stage #(.AMT(2)) u_stage1 (.in(w_st0), .en(w_n[1]), .out(w_st1));
    rot_stage #(.AMT(4)) u_stage2 (.in(w_st1), .en(w_n[2]), .out(w_st2));
    rot_stage #(.AMT(8)) u_stage3 (.in(w_st2), .en(w_n[3]), .out(w_st3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
        end else begin
            r_s <= w_st3;
        end
    end

    assign S = r_s;
endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed vectors plus random traffic against a bit-index rotate model.
module tb_top;
    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic        s0, s1, s2, s3;
    logic [15:0] S;

    int total = 0;
    int bad   = 0;

    top #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .A(A),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .S(S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: every bit i of a lands at position (i+n) mod 16.
    function automatic logic [15:0] ref_rotl(input logic [15:0] a, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[(i + n) % 16] = a[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        total++;
        assert (S === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, S, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input int n);
        logic [3:0] nb;
        nb = n[3:0];
        A  = a;
        s0 = nb[0];
        s1 = nb[1];
        s2 = nb[2];
        s3 = nb[3];
    endtask

    // Drive on the falling edge, then check #1 after the following rising edge.
    task automatic step(input string tag, input logic [15:0] a, input int n, input logic [15:0] exp);
        @(negedge clk);
        drive(a, n);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [15:0] sweep_exp [16];
        logic [15:0] ra;
        int          rn;

        sweep_exp = '{16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800,
                      16'h1000, 16'h2000, 16'h4000, 16'h8000, 16'h0001, 16'h0002,
                      16'h0004, 16'h0008, 16'h0010, 16'h0020};

        // Reset holds S at zero immediately and across edges
        rst_n = 1'b0;
        drive(16'hFFFF, 5);
        #1;
        check("reset_immediate", 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 16'hFFFF);

        for (int n = 0; n < 16; n++)
            step("sweep_bit6", 16'h0040, n, sweep_exp[n]);

        for (int n = 0; n < 16; n++)
            step("all_zero", 16'h0000, n, 16'h0000);

        step("wrap_8001_n1",  16'h8001, 1,  16'h0003);
        step("wrap_8001_n15", 16'h8001, 15, 16'hC000);
        step("wrap_1234_n4",  16'h1234, 4,  16'h2341);

        // Inputs changing between edges must not disturb S
        @(negedge clk);
        drive(16'hA5C3, 3);
        #2;
        check("no_comb_path", 16'h2341);
        @(posedge clk);
        #1;
        check("after_change", ref_rotl(16'hA5C3, 3));

        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom);
            rn = int'($urandom_range(15, 0));
            step("random", ra, rn, ref_rotl(ra, rn));
        end

        // Mid-run reset between edges, S known nonzero beforehand
        step("pre_reset", 16'hBEEF, 7, ref_rotl(16'hBEEF, 7));
        @(negedge clk);
        drive(16'h1357, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset", 16'h0000);
        @(posedge clk);
        #1;
        check("midrun_reset_hold", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_resume", ref_rotl(16'h1357, 9));
        step("post_resume", 16'h00F0, 12, ref_rotl(16'h00F0, 12));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
